// File: rtl/pcecd_pkg.sv
// Shared types and constants for the PC Engine CD SCSI target engine.
package pcecd_pkg;

  typedef enum logic [2:0] {
    BUS_FREE,
    COMMAND,
    EXEC,
    DATA_IN,
    STATUS,
    MSG_IN
  } phase_t;

  // Bus phase bits as {msg, cd, io}
  localparam logic [2:0] PH_NONE    = 3'b000;
  localparam logic [2:0] PH_COMMAND = 3'b010;
  localparam logic [2:0] PH_DATA_IN = 3'b001;
  localparam logic [2:0] PH_STATUS  = 3'b011;
  localparam logic [2:0] PH_MSG_IN  = 3'b111;

  localparam logic [7:0] MSG_CMD_COMPLETE = 8'h00;

  // Command length from the opcode group, clipped to the capture buffer size
  function automatic logic [4:0] cmd_group_len(input logic [7:0] opcode,
                                               input int unsigned cmd_max);
    logic [4:0] len;
    case (opcode[7:5])
      3'd0:       len = 5'd6;
      3'd1, 3'd2: len = 5'd10;
      default:    len = 5'd12;
    endcase
    if ({27'd0, len} > cmd_max) len = cmd_max[4:0];
    return len;
  endfunction

endpackage

// File: rtl/pcecd_sync_fifo.sv
// Show-ahead synchronous FIFO buffering drive data for the DATA IN phase.
module pcecd_sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [FIFO_AW:0]  count
);

  logic [DATA_W-1:0]  mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               do_push, do_pop;

  assign full    = (count == (FIFO_AW + 1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pcecd_scsi_target.sv
// SCSI target bus engine: SEL detect, REQ/ACK byte handshake, command capture,
// buffered DATA IN, STATUS and MESSAGE IN phases, plus the IRQ2 sources.
module pcecd_scsi_target
  import pcecd_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned CMD_MAX    = 12,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sel_i,
  input  logic                      ack_i,
  input  logic                      rst_i,
  input  logic                      db_wr_i,
  input  logic [DATA_W-1:0]         db_i,
  output logic [DATA_W-1:0]         db_o,
  output logic                      bsy_o,
  output logic                      req_o,
  output logic                      msg_o,
  output logic                      cd_o,
  output logic                      io_o,
  output logic                      cmd_valid_o,
  output logic [CMD_MAX*DATA_W-1:0] cmd_o,
  output logic [4:0]                cmd_len_o,
  input  logic                      cmd_ack_i,
  input  logic                      dat_valid_i,
  input  logic [DATA_W-1:0]         dat_i,
  output logic                      dat_ready_o,
  input  logic                      stat_valid_i,
  input  logic [DATA_W-1:0]         stat_i,
  output logic                      irq_ready_o,
  output logic                      irq_done_o
);

  phase_t                    state_q, state_d;
  logic                      req_q, req_d, ack_q, ack_rise, commit;
  logic                      cmd_valid_q, cmd_valid_d;
  logic                      stat_pend_q, stat_pend_d, stat_ld;
  logic                      irq_done_q, irq_done_d;
  logic [4:0]                idx_q, idx_d, len_q, len_d, len_now;
  logic [DATA_W-1:0]         db_q, stat_q;
  logic [CMD_MAX*DATA_W-1:0] cmd_buf;
  logic                      cap, pop, byte_avail;
  logic                      fifo_full, fifo_empty;
  logic [DATA_W-1:0]         fifo_head;
  logic [FIFO_AW:0]          fifo_count;

  pcecd_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (rst_i),
    .push  (dat_valid_i),
    .wdata (dat_i),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign ack_rise = ack_i & ~ack_q;
  assign commit   = req_q & ack_rise;

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cmd_valid_d = cmd_valid_q;
    stat_pend_d = stat_pend_q;
    stat_ld     = 1'b0;
    irq_done_d  = 1'b0;
    idx_d       = idx_q;
    len_d       = len_q;
    len_now     = len_q;
    cap         = 1'b0;
    pop         = 1'b0;
    byte_avail  = 1'b0;

    // Status may arrive while data is still queued; hold it until DATA IN drains
    if ((state_q == EXEC || state_q == DATA_IN) && stat_valid_i && !stat_pend_q) begin
      stat_ld     = 1'b1;
      stat_pend_d = 1'b1;
    end

    case (state_q)
      BUS_FREE: begin
        if (sel_i) begin
          state_d = COMMAND;
          req_d   = 1'b1;
          idx_d   = '0;
          len_d   = '0;
        end
      end
      COMMAND: begin
        byte_avail = 1'b1;
        if (commit) begin
          cap   = 1'b1;
          idx_d = idx_q + 5'd1;
          if (idx_q == '0) begin
            len_now = cmd_group_len(db_q[7:0], CMD_MAX);
            len_d   = len_now;
          end
          if (idx_q + 5'd1 == len_now) begin
            state_d     = EXEC;
            cmd_valid_d = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cmd_valid_q) begin
          if (cmd_ack_i) cmd_valid_d = 1'b0;
        end else if (!fifo_empty) begin
          state_d = DATA_IN;
        end else if (stat_pend_q || stat_valid_i) begin
          state_d = STATUS;
        end
      end
      DATA_IN: begin
        byte_avail = ~fifo_empty;
        if (commit) begin
          pop = 1'b1;
        end else if (!req_q && fifo_empty) begin
          state_d = (stat_pend_q || stat_valid_i) ? STATUS : EXEC;
        end
      end
      STATUS: begin
        byte_avail = 1'b1;
        if (commit) begin
          state_d     = MSG_IN;
          stat_pend_d = 1'b0;
        end
      end
      MSG_IN: begin
        byte_avail = 1'b1;
        if (commit) begin
          state_d    = BUS_FREE;
          irq_done_d = 1'b1;
        end
      end
      default: state_d = BUS_FREE;
    endcase

    // Next REQ waits for ACK to be seen low, so a held ACK cannot double-commit
    if (commit) req_d = 1'b0;
    else if (!req_q && !ack_i && byte_avail && state_d == state_q) req_d = 1'b1;

    if (rst_i) begin
      state_d     = BUS_FREE;
      req_d       = 1'b0;
      cmd_valid_d = 1'b0;
      stat_pend_d = 1'b0;
      stat_ld     = 1'b0;
      irq_done_d  = 1'b0;
      idx_d       = '0;
      len_d       = '0;
      cap         = 1'b0;
      pop         = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= BUS_FREE;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      stat_pend_q <= 1'b0;
      irq_done_q  <= 1'b0;
      idx_q       <= '0;
      len_q       <= '0;
      db_q        <= '0;
      stat_q      <= '0;
      cmd_buf     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      ack_q       <= ack_i;
      cmd_valid_q <= cmd_valid_d;
      stat_pend_q <= stat_pend_d;
      irq_done_q  <= irq_done_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      if (rst_i) begin
        db_q    <= '0;
        stat_q  <= '0;
        cmd_buf <= '0;
      end else begin
        if (state_q == COMMAND && db_wr_i) db_q <= db_i;
        if (stat_ld) stat_q <= stat_i;
        if (cap) begin
          for (int unsigned i = 0; i < CMD_MAX; i++) begin
            if (idx_q == i[4:0]) cmd_buf[i*DATA_W +: DATA_W] <= db_q;
          end
        end
      end
    end
  end

  always_comb begin
    bsy_o = (state_q != BUS_FREE);
    db_o  = '0;
    {msg_o, cd_o, io_o} = PH_NONE;
    case (state_q)
      COMMAND: {msg_o, cd_o, io_o} = PH_COMMAND;
      DATA_IN: begin
        {msg_o, cd_o, io_o} = PH_DATA_IN;
        db_o = fifo_head;
      end
      STATUS: begin
        {msg_o, cd_o, io_o} = PH_STATUS;
        db_o = stat_q;
      end
      MSG_IN: begin
        {msg_o, cd_o, io_o} = PH_MSG_IN;
        db_o = DATA_W'(MSG_CMD_COMPLETE);
      end
      default: ;
    endcase
  end

  assign req_o       = req_q;
  assign cmd_valid_o = cmd_valid_q;
  assign cmd_o       = cmd_buf;
  assign cmd_len_o   = len_q;
  assign dat_ready_o = ~fifo_full;
  assign irq_ready_o = (state_q == DATA_IN) && (fifo_count != '0);
  assign irq_done_o  = irq_done_q;

endmodule
